multimode_shift_counter: RTL and testbench
==========================================

// Module: multimode_shift_counter
// PURPOSE
//  Parametrised sequence generator: one counter register stepped by a prescaler
//  and run as Johnson, ring, Fibonacci LFSR or binary up/down counter.
//  Adds direction, enable, synchronous load, illegal-state recovery and
//  tick/wrap strobes. Its q output drives the tile outputs and feeds the PWM path.
// PARAMETERS
//  WIDTH       8      counter width in bits, >= 2
//  PRESCALE_W  8      prescaler compare width
//  TAPS        8'hB8  LFSR feedback mask, WIDTH bits; default is maximal for WIDTH=8
// PORTS
//  clk       in   1           clock, all logic on rising edge
//  rst_n     in   1           synchronous active-low reset
//  en        in   1           prescaler/step enable
//  mode      in   2           00 Johnson, 01 ring, 10 LFSR, 11 binary
//  dir       in   1           0 up/left, 1 down/right; ignored in LFSR mode
//  load      in   1           synchronous load strobe
//  load_val  in   WIDTH       value written to q on load
//  prescale  in   PRESCALE_W  step every prescale+1 enabled cycles
//  q         out  WIDTH       counter state, registered
//  tick      out  1           1-cycle pulse, coincident with each new q from a step
//  wrap      out  1           1-cycle pulse when a step lands q on the mode seed
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): q=0, pcnt=0, tick=0, wrap=0.
//  - Priority: reset > load > step > hold.
//  - Prescaler: pcnt advances only when en=1. When pcnt==prescale: step, pcnt->0.
//    Otherwise pcnt+1. prescale=0 steps every enabled cycle.
//  - en=0 holds pcnt and q. tick=wrap=0.
//  - A prescale change takes effect at the next compare. If pcnt>prescale, pcnt
//    counts up, wraps modulo 2^PRESCALE_W, then matches.
//  - Load: q<=load_val and pcnt<=0, independent of en. tick=wrap=0 that cycle.
//  - Step, Johnson:
//      dir0: q<={q[W-2:0],~q[W-1]}
//      dir1: q<={~q[0],q[W-1:1]}
//    Legal means at most one adjacent-bit transition across q[W-1:0].
//    Stepping from an illegal q gives q=0.
//  - Step, ring:
//      dir0: rotate left
//      dir1: rotate right
//    q==0 steps to 1, not rotated.
//  - Step, LFSR: fb=^(q&TAPS); q<={q[W-2:0],fb}. q==0 steps to 1 (lock-up escape).
//  - Step, binary: dir0 q+1, dir1 q-1, modulo 2^WIDTH.
//  - Seed: Johnson 0; ring 1; LFSR 1; binary dir0 0, binary dir1 all-ones.
//    wrap=1 when the stepped q equals the seed. Forced recoveries also count.
//  - tick and wrap are registered and valid in the same cycle as the new q.
//  - Mode/dir change: q is not cleared. The next step applies the new rule.
//    The Johnson legality check covers entry from other modes.
//  - Reset mid-prescale or mid-sequence: all state cleared on that edge.
// TESTING
//  1 Johnson, W=8, dir0, prescale0, en=1 from reset:
//    q=01,03,07,0F,1F,3F,7F,FF,FE,FC,F8,F0,E0,C0,80,00.
//    wrap only on the 16th step; tick every cycle.
//  2 Johnson dir1 from 00 -> 80,C0,E0 -> then load 5A:
//    load cycle tick=0; next step q=00, wrap=1; next step q=80.
//  3 prescale=3 -> tick every 4th cycle. Drop en for 5 cycles mid-count:
//    q and pcnt frozen. Resume: remaining count honoured.
//  4 Ring, load 00, step -> q=01, wrap=1.
//    dir0 then 02,04,...,80,01, wrap on the 8th; dir1 from 01 -> 80.
//  5 LFSR TAPS=B8 from reset -> first step q=01 with wrap.
//    255 further steps, wrap exactly once more; q never 00.
//  6 Binary dir1 from 00 -> FF with wrap=1.
//    Assert rst_n=0 together with load=1 -> q=00, tick=0, wrap=0.

Source files
------------

// File: rtl/multimode_shift_counter.sv
// Prescaled multi-mode sequence generator: Johnson, ring, Fibonacci LFSR or
// binary up/down counter in one register, with load, illegal-state recovery and tick/wrap strobes.
module multimode_shift_counter #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned PRESCALE_W = 8,
  parameter logic [WIDTH-1:0] TAPS  = 8'hB8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [1:0]            mode,
  input  logic                  dir,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [WIDTH-1:0]      q,
  output logic                  tick,
  output logic                  wrap
);

  typedef enum logic [1:0] {
    MODE_JOHNSON = 2'b00,
    MODE_RING    = 2'b01,
    MODE_LFSR    = 2'b10,
    MODE_BINARY  = 2'b11
  } mode_e;

  logic [PRESCALE_W-1:0] pcnt;
  logic [WIDTH-1:0]      q_next;
  logic [WIDTH-1:0]      seed;
  logic [WIDTH-2:0]      edges;
  logic                  johnson_legal;
  logic                  step;

  // A legal Johnson word has at most one place where neighbouring bits differ.
  assign edges         = q[WIDTH-1:1] ^ q[WIDTH-2:0];
  assign johnson_legal = (edges & (edges - (WIDTH-1)'(1))) == '0;
  assign step          = en && (pcnt == prescale);

  always_comb begin
    q_next = q;
    seed   = '0;
    case (mode_e'(mode))
      MODE_JOHNSON: begin
        seed = '0;
        if (!johnson_legal) q_next = '0;
        else if (dir)       q_next = {~q[0], q[WIDTH-1:1]};
        else                q_next = {q[WIDTH-2:0], ~q[WIDTH-1]};
      end
      MODE_RING: begin
        seed = WIDTH'(1);
        if (q == '0)  q_next = WIDTH'(1);
        else if (dir) q_next = {q[0], q[WIDTH-1:1]};
        else          q_next = {q[WIDTH-2:0], q[WIDTH-1]};
      end
      MODE_LFSR: begin
        // All-zero is the lock-up state of an XOR LFSR; escape to the seed.
        seed = WIDTH'(1);
        if (q == '0) q_next = WIDTH'(1);
        else         q_next = {q[WIDTH-2:0], ^(q & TAPS)};
      end
      default: begin
        seed   = dir ? '1 : '0;
        q_next = dir ? (q - WIDTH'(1)) : (q + WIDTH'(1));
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q    <= '0;
      pcnt <= '0;
      tick <= 1'b0;
      wrap <= 1'b0;
    end else if (load) begin
      q    <= load_val;
      pcnt <= '0;
      tick <= 1'b0;
      wrap <= 1'b0;
    end else if (step) begin
      q    <= q_next;
      pcnt <= '0;
      tick <= 1'b1;
      wrap <= (q_next == seed);
    end else begin
      // Past a lowered compare value pcnt keeps counting and wraps around.
      if (en) pcnt <= pcnt + PRESCALE_W'(1);
      tick <= 1'b0;
      wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_multimode_shift_counter.sv
// Directed bench for multimode_shift_counter: a behavioural model pushes the
// expected {q,tick,wrap} per clock into a queue that is popped after each edge.
module tb_multimode_shift_counter;

  localparam int W  = 8;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [1:0]    mode;
  logic          dir;
  logic          load;
  logic [W-1:0]  load_val;
  logic [PW-1:0] prescale;
  logic [W-1:0]  q;
  logic          tick;
  logic          wrap;

  logic [W+1:0]  exp_q[$];
  int            n_assert = 0;
  int            n_fail   = 0;

  logic [W-1:0]  m_q;
  logic [PW-1:0] m_pcnt;
  logic          m_tick;
  logic          m_wrap;

  multimode_shift_counter #(.WIDTH(W), .PRESCALE_W(PW), .TAPS(8'hB8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .dir(dir), .load(load),
    .load_val(load_val), .prescale(prescale), .q(q), .tick(tick), .wrap(wrap)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] next_val(input logic [W-1:0] v);
    int t;
    logic fb;
    case (mode)
      2'b00: begin
        t = 0;
        for (int i = 0; i < W-1; i++) if (v[i] != v[i+1]) t++;
        if (t > 1)    return '0;
        else if (dir) return {~v[0], v[W-1:1]};
        else          return {v[W-2:0], ~v[W-1]};
      end
      2'b01: begin
        if (v == 0)   return 8'h01;
        else if (dir) return {v[0], v[W-1:1]};
        else          return {v[W-2:0], v[W-1]};
      end
      2'b10: begin
        if (v == 0) return 8'h01;
        fb = v[7] ^ v[5] ^ v[4] ^ v[3];
        return {v[W-2:0], fb};
      end
      default: return dir ? v - 8'd1 : v + 8'd1;
    endcase
  endfunction

  function automatic logic [W-1:0] seed_of();
    case (mode)
      2'b00:   return 8'h00;
      2'b01:   return 8'h01;
      2'b10:   return 8'h01;
      default: return dir ? 8'hFF : 8'h00;
    endcase
  endfunction

  task automatic model_update();
    logic [W-1:0] nq;
    m_tick = 1'b0;
    m_wrap = 1'b0;
    if (!rst_n) begin
      m_q = '0; m_pcnt = '0;
    end else if (load) begin
      m_q = load_val; m_pcnt = '0;
    end else if (en) begin
      if (m_pcnt == prescale) begin
        nq = next_val(m_q);
        m_tick = 1'b1;
        m_wrap = (nq == seed_of());
        m_q = nq;
        m_pcnt = '0;
      end else begin
        m_pcnt = m_pcnt + 8'd1;
      end
    end
  endtask

  task automatic step_expect(input string tag, input logic [W+1:0] e);
    logic [W+1:0] got, want;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got  = {q, tick, wrap};
    want = exp_q.pop_front();
    n_assert++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: got q=%h tick=%b wrap=%b, expected q=%h tick=%b wrap=%b",
             tag, got[W+1:2], got[1], got[0], want[W+1:2], want[1], want[0]);
    end
  endtask

  task automatic step_model(input string tag);
    model_update();
    step_expect(tag, {m_q, m_tick, m_wrap});
  endtask

  task automatic check_int(input string tag, input int got, input int want);
    n_assert++;
    assert (got == want) else begin
      n_fail++;
      $error("FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  initial begin
    logic [W-1:0] j_tbl [16];
    int wraps;
    int zeros;
    j_tbl = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
              8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};
    rst_n = 1'b0; en = 1'b0; mode = 2'b00; dir = 1'b0;
    load = 1'b0; load_val = '0; prescale = '0;
    m_q = '0; m_pcnt = '0; m_tick = 1'b0; m_wrap = 1'b0;
    @(posedge clk); #1;
    step_model("reset");

    // Johnson up, full cycle, against the literal sequence.
    rst_n = 1'b1; en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      model_update();
      step_expect($sformatf("johnson_up_%0d", i), {j_tbl[i], 1'b1, (i == 15)});
    end

    // Johnson down, then load an illegal word and recover.
    dir = 1'b1;
    for (int i = 0; i < 3; i++) step_model("johnson_down");
    load = 1'b1; load_val = 8'h5A;
    step_model("load_5a");
    load = 1'b0;
    step_expect("johnson_recover", {8'h00, 1'b1, 1'b1});
    model_update();
    step_expect("johnson_after_recover", {8'h80, 1'b1, 1'b0});
    model_update();
    m_q = 8'h80; // keep model aligned even if it diverged

    // Prescale 3 in binary up, with an en gap mid-count.
    mode = 2'b11; dir = 1'b0; prescale = 8'd3;
    load = 1'b1; load_val = 8'h00;
    step_model("bin_load");
    load = 1'b0;
    for (int i = 0; i < 6; i++) step_model("presc_run");
    en = 1'b0;
    for (int i = 0; i < 5; i++) step_model("presc_hold");
    en = 1'b1;
    for (int i = 0; i < 8; i++) step_model("presc_resume");

    // Lower the compare value below pcnt: pcnt must wrap before matching.
    prescale = 8'd7;
    load = 1'b1; load_val = 8'h10;
    step_model("presc_reload");
    load = 1'b0;
    for (int i = 0; i < 4; i++) step_model("presc7");
    prescale = 8'd1;
    for (int i = 0; i < 256; i++) step_model("presc_wrap");

    // Ring: zero escapes to 1 with wrap, then rotates both ways.
    mode = 2'b01; dir = 1'b0; prescale = '0;
    load = 1'b1; load_val = 8'h00;
    step_model("ring_load");
    load = 1'b0;
    step_expect("ring_escape", {8'h01, 1'b1, 1'b1});
    model_update();
    for (int i = 0; i < 8; i++) step_model("ring_left");
    dir = 1'b1;
    model_update();
    step_expect("ring_right", {8'h80, 1'b1, 1'b0});

    // LFSR from reset: full period, single extra wrap, never zero.
    mode = 2'b10; rst_n = 1'b0;
    step_model("lfsr_reset");
    rst_n = 1'b1;
    model_update();
    step_expect("lfsr_first", {8'h01, 1'b1, 1'b1});
    wraps = 0; zeros = 0;
    for (int i = 0; i < 255; i++) begin
      step_model("lfsr_run");
      if (wrap) wraps++;
      if (q == 8'h00) zeros++;
    end
    check_int("lfsr_wraps", wraps, 1);
    check_int("lfsr_zeros", zeros, 0);
    check_int("lfsr_period_end", int'(q), 1);

    // Binary down from zero, then reset wins over load.
    mode = 2'b11; dir = 1'b1;
    load = 1'b1; load_val = 8'h00;
    step_model("bin_load0");
    load = 1'b0;
    model_update();
    step_expect("bin_down_wrap", {8'hFF, 1'b1, 1'b1});
    step_model("bin_down");
    rst_n = 1'b0; load = 1'b1; load_val = 8'hA5;
    model_update();
    step_expect("reset_over_load", {8'h00, 1'b0, 1'b0});
    rst_n = 1'b1; load = 1'b0; prescale = 8'd2;
    for (int i = 0; i < 6; i++) step_model("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
